// File: rtl/data_stream.sv
// Frame merger: header word, L_WORDS left-source words, then R_WORDS right-source words.
// Define DATA_STREAM_CHECKSUM_EN to append a 32-bit sum-of-payload trailer word.
module data_stream #(
    parameter int          L_WORDS = 512,
    parameter int          R_WORDS = 512,
    parameter logic [15:0] HDR_TAG = 16'hA55A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_sync,
    output logic        o_sync_pulse,
    input  logic [31:0] i_l_data,
    input  logic        i_l_valid,
    output logic        o_l_ready,
    input  logic [31:0] i_r_data,
    input  logic        i_r_valid,
    output logic        o_r_ready,
    output logic [31:0] o_data,
    output logic        o_valid,
    input  logic        i_out_ready
);
    localparam logic [15:0] L_LAST = 16'(L_WORDS - 1);
    localparam logic [15:0] R_LAST = 16'(R_WORDS - 1);

`ifdef DATA_STREAM_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR, LEFT, RIGHT, SUM} state_t;
`else
    typedef enum logic [1:0] {IDLE, HDR, LEFT, RIGHT} state_t;
`endif

    state_t      state;
    logic        sync_q;
    logic [15:0] word_cnt;
    logic [15:0] frame_cnt;
    logic        sync_fall;
    logic        xfer;

    assign sync_fall = sync_q & ~i_sync;
    assign xfer      = o_valid & i_out_ready;

`ifdef DATA_STREAM_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sync_q       <= 1'b1;
            o_sync_pulse <= 1'b0;
            word_cnt     <= '0;
            frame_cnt    <= '0;
`ifdef DATA_STREAM_CHECKSUM_EN
            checksum     <= '0;
`endif
        end else begin
            sync_q       <= i_sync;
            o_sync_pulse <= sync_fall;
            // A sync edge aborts whatever is in flight; the pulse cycle then arms a new frame.
            if (sync_fall) begin
                state <= IDLE;
            end else if (o_sync_pulse) begin
                state    <= HDR;
                word_cnt <= '0;
`ifdef DATA_STREAM_CHECKSUM_EN
                checksum <= '0;
`endif
            end else begin
                case (state)
                    HDR: if (xfer) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        state     <= LEFT;
                    end
                    LEFT: if (xfer) begin
`ifdef DATA_STREAM_CHECKSUM_EN
                        checksum <= checksum + o_data;
`endif
                        if (word_cnt == L_LAST) begin
                            word_cnt <= '0;
                            state    <= RIGHT;
                        end else begin
                            word_cnt <= word_cnt + 16'd1;
                        end
                    end
                    RIGHT: if (xfer) begin
`ifdef DATA_STREAM_CHECKSUM_EN
                        checksum <= checksum + o_data;
`endif
                        if (word_cnt == R_LAST) begin
                            word_cnt <= '0;
`ifdef DATA_STREAM_CHECKSUM_EN
                            state    <= SUM;
`else
                            state    <= IDLE;
`endif
                        end else begin
                            word_cnt <= word_cnt + 16'd1;
                        end
                    end
`ifdef DATA_STREAM_CHECKSUM_EN
                    SUM: if (xfer) state <= IDLE;
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Payload states are a straight pass-through so a stalled sink holds the source word.
    always_comb begin
        o_valid   = 1'b0;
        o_data    = '0;
        o_l_ready = 1'b0;
        o_r_ready = 1'b0;
        case (state)
            HDR: begin
                o_valid = 1'b1;
                o_data  = {HDR_TAG, frame_cnt};
            end
            LEFT: begin
                o_valid   = i_l_valid;
                o_data    = i_l_data;
                o_l_ready = i_out_ready;
            end
            RIGHT: begin
                o_valid   = i_r_valid;
                o_data    = i_r_data;
                o_r_ready = i_out_ready;
            end
`ifdef DATA_STREAM_CHECKSUM_EN
            SUM: begin
                o_valid = 1'b1;
                o_data  = checksum;
            end
`endif
            default: ;
        endcase
    end
endmodule

// File: tb/tb_data_stream.sv
// Randomized bench for data_stream against a frame-position reference model.
module tb_data_stream;
    localparam int L = 512;
    localparam int R = 512;
`ifdef DATA_STREAM_CHECKSUM_EN
    localparam int LASTPOS = L + R + 1;
`else
    localparam int LASTPOS = L + R;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_sync;
    logic        o_sync_pulse;
    logic [31:0] i_l_data, i_r_data, o_data;
    logic        i_l_valid, i_r_valid, o_l_ready, o_r_ready, o_valid, i_out_ready;

    data_stream dut (
        .clk(clk), .rst_n(rst_n), .i_sync(i_sync), .o_sync_pulse(o_sync_pulse),
        .i_l_data(i_l_data), .i_l_valid(i_l_valid), .o_l_ready(o_l_ready),
        .i_r_data(i_r_data), .i_r_valid(i_r_valid), .o_r_ready(o_r_ready),
        .o_data(o_data), .o_valid(o_valid), .i_out_ready(i_out_ready)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: frame position 0 = header, 1..L left, L+1..L+R right, then trailer.
    bit          m_active, m_pulse, m_sync_prev, seq_mode;
    int          m_pos, l_idx, r_idx;
    logic [15:0] m_fcnt;
    logic [31:0] m_sum, l_cur, r_cur;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] gen(input int idx);
        return seq_mode ? 32'(idx) : $urandom();
    endfunction

    task automatic model_reset();
        m_active = 0; m_pulse = 0; m_sync_prev = 1; m_pos = 0;
        m_fcnt = 0; m_sum = 0; l_idx = 0; r_idx = 0;
    endtask

    // One clock: check outputs at negedge, then advance the model across the posedge.
    task automatic cyc();
        logic        ev, el, er, s_xfer, s_la, s_ra, s_sync, fall;
        logic [31:0] ed;
        @(negedge clk);
        ev = 0; el = 0; er = 0; ed = '0;
        if (m_active && !m_pulse) begin
            if (m_pos == 0) begin ev = 1; ed = {16'hA55A, m_fcnt}; end
            else if (m_pos <= L) begin ev = i_l_valid; ed = i_l_data; el = i_out_ready; end
            else if (m_pos <= L + R) begin ev = i_r_valid; ed = i_r_data; er = i_out_ready; end
            else begin ev = 1; ed = m_sum; end
        end
        chk("sync_pulse", o_sync_pulse, m_pulse);
        chk("o_valid", o_valid, ev);
        chk("o_data", o_data, ed);
        chk("o_l_ready", o_l_ready, el);
        chk("o_r_ready", o_r_ready, er);
        chk("ready_excl", o_l_ready & o_r_ready, 0);
        s_xfer = ev & i_out_ready; s_la = el & i_l_valid; s_ra = er & i_r_valid; s_sync = i_sync;
        @(posedge clk);
        if (s_la) begin l_idx++; l_cur = gen(l_idx); end
        if (s_ra) begin r_idx++; r_cur = gen(r_idx); end
        fall = m_sync_prev && !s_sync;
        if (fall) begin
            m_pulse = 1; m_active = 0;
        end else if (m_pulse) begin
            m_pulse = 0; m_active = 1; m_pos = 0; m_sum = 0;
            l_idx = 0; r_idx = 0; l_cur = gen(0); r_cur = gen(0);
        end else if (m_active && s_xfer) begin
            if (m_pos == 0) m_fcnt = m_fcnt + 16'd1;
            else if (m_pos <= L + R) m_sum = m_sum + ed;
            if (m_pos == LASTPOS) m_active = 0;
            else m_pos++;
        end
        m_sync_prev = s_sync;
        #1;
    endtask

    task automatic drive(input int lp, input int rp, input int op);
        i_l_valid   = ($urandom_range(99) < lp);
        i_r_valid   = ($urandom_range(99) < rp);
        i_out_ready = ($urandom_range(99) < op);
        i_l_data    = l_cur;
        i_r_data    = r_cur;
    endtask

    task automatic run(input int n, input int lp, input int rp, input int op);
        for (int i = 0; i < n; i++) begin
            drive(lp, rp, op);
            cyc();
        end
    endtask

    task automatic run_until_pos(input int pos, input int lp, input int rp, input int op);
        int guard = 0;
        while (m_active && m_pos < pos && guard < 20000) begin
            run(1, lp, rp, op);
            guard++;
        end
        if (guard >= 20000) begin
            vectors++; miscompares++;
            $error("FAIL timeout waiting for pos %0d observed=%0d", pos, m_pos);
        end
    endtask

    task automatic start_frame(input logic [31:0] hdr);
        drive(100, 100, 0);
        i_sync = 1'b0;
        cyc();
        chk("pulse_hi", o_sync_pulse, 1);
        drive(100, 100, 100);
        i_sync = 1'b1;
        #1;
        chk("pulse_l_ready", o_l_ready, 0);
        chk("pulse_r_ready", o_r_ready, 0);
        cyc();
        chk("pulse_lo", o_sync_pulse, 0);
        chk("header", o_data, hdr);
    endtask

    initial begin
        logic [31:0] held;
        int          pos_before;
        rst_n = 0; i_sync = 1; i_l_valid = 0; i_r_valid = 0; i_out_ready = 0;
        i_l_data = 0; i_r_data = 0;
        seq_mode = 1; model_reset(); l_cur = 0; r_cur = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_pulse", o_sync_pulse, 0);
        chk("rst_readies", {o_l_ready, o_r_ready}, 0);
        rst_n = 1;
        run(3, 50, 50, 50);

        // Frame 0: counting payload, everything always ready.
        start_frame(32'hA55A0000);
        run_until_pos(LASTPOS, 100, 100, 100);
`ifdef DATA_STREAM_CHECKSUM_EN
        chk("trailer", o_data, 32'h0003FE00);
`endif
        run_until_pos(LASTPOS + 1, 100, 100, 100);
        run(2, 100, 100, 100);

        // Frame 1: random data, sink stall and source gap in LEFT.
        seq_mode = 0;
        start_frame(32'hA55A0001);
        run_until_pos(100, 80, 80, 80);
        drive(100, 100, 0);
        for (int i = 0; i < 10; i++) begin
            #1;
            if (i == 0) held = o_data;
            chk("stall_data", o_data, held);
            chk("stall_valid", o_valid, 1);
            chk("stall_l_ready", o_l_ready, 0);
            cyc();
        end
        pos_before = m_pos;
        for (int i = 0; i < 5; i++) begin
            drive(0, 100, 100);
            i_l_valid = 0;
            #1;
            chk("gap_valid", o_valid, 0);
            cyc();
        end
        chk("gap_pos", 32'(m_pos), 32'(pos_before));
        run_until_pos(LASTPOS + 1, 70, 70, 70);
        run(2, 50, 50, 50);

        // Frame 2 aborted mid-RIGHT; frame 3 header carries the incremented count.
        start_frame(32'hA55A0002);
        run_until_pos(L + 20, 90, 90, 90);
        start_frame(32'hA55A0003);
        run(200, 60, 60, 60);

        // Reset mid-frame, then a new frame starting from frame_cnt 0.
        rst_n = 0;
        model_reset();
        #1;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_data", o_data, 0);
        chk("midrst_readies", {o_l_ready, o_r_ready}, 0);
        @(posedge clk); #1;
        rst_n = 1;
        run(5, 50, 50, 50);
        start_frame(32'hA55A0000);
        run_until_pos(LASTPOS + 1, 75, 75, 75);
        run(3, 50, 50, 50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
